// File: rtl/projection_burst_sequencer_pkg.sv
// Shared definitions for the projection burst sequencer.
// Contents: sequencer state encoding, AXI response/burst/size codes,
// status bit positions, beat-counter width and the 4 KB crossing test.
package projection_burst_sequencer_pkg;

    localparam int MAX_LEN = 256;
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B         = 3'b010;

    // status[] bit positions
    localparam int ST_BRESP = 0;
    localparam int ST_RERR  = 1;
    localparam int ST_4K    = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_e;

    // True when a burst of (len+1) 4-byte beats starting at page offset
    // 'off' would run past the end of its 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] off, input logic [CNT_W-1:0] len);
        logic [13:0] end_off;
        end_off = {2'b00, off} + (({{(14-CNT_W){1'b0}}, len} + 14'd1) << 2);
        return end_off > 14'd4096;
    endfunction

endpackage

// File: rtl/projection_burst_sequencer_if.sv
// AXI4 master-side bus between the sequencer and the projection core.
// Signals: AW (addr,len,size,burst,valid/ready), W (data,strb,last,valid/ready),
// B (resp,valid/ready), AR (addr,len,size,burst,valid/ready), R (data,resp,last,valid/ready).
// Handshake rule for every channel: a transfer happens on the clock edge where
// valid and ready are both high; a source holding valid keeps its payload
// stable until that edge, and valid never depends on ready.
interface projection_burst_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arsize, arburst, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/projection_burst_sequencer.sv
// Runs one projection job: writes (cmd_len+1) stream words as one AXI INCR
// burst, waits for BRESP, reads the same window back and streams it out.
// Ports: ACLK/ARESETN clock and async active-low reset; cmd_valid/ready,
// cmd_addr, cmd_len job command; in_t* write-data stream; out_t* readback
// stream; done one-cycle end-of-job pulse; status error flags; m_axi AXI4
// master bus; dbg_state current sequencer state.
module projection_burst_sequencer
    import projection_burst_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic [DATA_W-1:0] in_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tlast,
    output logic              done,
    output logic [2:0]        status,
    output state_e            dbg_state,
    projection_burst_sequencer_if.master m_axi
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        status_q, status_d;
    logic              beat_last;

    assign beat_last = (cnt_q == len_q);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        status_d       = status_q;
        cmd_ready      = 1'b0;
        in_tready      = 1'b0;
        out_tvalid     = 1'b0;
        out_tlast      = 1'b0;
        done           = 1'b0;
        m_axi.awvalid  = 1'b0;
        m_axi.wvalid   = 1'b0;
        m_axi.bready   = 1'b0;
        m_axi.arvalid  = 1'b0;
        m_axi.rready   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                cnt_d     = '0;
                if (cmd_valid) begin
                    // Word-align: the two low address bits are ignored.
                    addr_d   = cmd_addr & ~ADDR_W'(3);
                    len_d    = cmd_len;
                    status_d = '0;
                    state_d  = S_CHK;
                end
            end
            S_CHK: begin
                if (crosses_4k(addr_q[11:0], len_q)) begin
                    status_d[ST_4K] = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    state_d = S_AW;
                end
            end
            S_AW: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) begin
                    cnt_d   = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                // Straight passthrough: the stream source sees the slave's wready.
                m_axi.wvalid = in_tvalid;
                in_tready    = m_axi.wready;
                if (in_tvalid && m_axi.wready) begin
                    if (beat_last) state_d = S_B;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    status_d[ST_BRESP] = (m_axi.bresp != AXI_RESP_OKAY);
                    state_d            = S_AR;
                end
            end
            S_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    cnt_d   = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                out_tvalid   = m_axi.rvalid;
                m_axi.rready = out_tready;
                out_tlast    = m_axi.rlast;
                if (m_axi.rvalid && out_tready) begin
                    // Flag a bad response or an RLAST that disagrees with our own count.
                    if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != beat_last))
                        status_d[ST_RERR] = 1'b1;
                    // Exit on our count, so beats past len are never accepted.
                    if (beat_last) state_d = S_DONE;
                    else           cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = SIZE_4B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wdata   = in_tdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (state_q == S_W) && beat_last;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = SIZE_4B;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign out_tdata     = m_axi.rdata;
    assign status        = status_q;
    assign dbg_state     = state_q;

endmodule
